peripheral_muldiv: RTL and testbench

Memory-mapped iterative multiply/divide unit on the rv32i peripheral bus; the successor to the single-mode multiplier peripheral. Operand width is parametrised, and it adds signed and unsigned multiply and divide, divide-by-zero and overflow handling, a start pulse instead of a level init, sticky done, and an interrupt. One sub-module does the arithmetic. The wrapper owns the register map, the handshake and the result registers.

---
 rtl/muldiv_pkg.sv | 43 ++++
 rtl/muldiv_core.sv | 161 ++++++++++++++++
 rtl/peripheral_muldiv.sv | 138 +++++++++++++
 tb/tb_peripheral_muldiv.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared encodings for the multiply/divide peripheral: op codes,
//                register addresses, CTRL/STATUS bit positions, core states.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Operation encodings; bit1 selects divide, bit0 selects signed
    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MULS = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIVS = 2'b11;

    // Word register addresses (bus address bits 4:2)
    localparam logic [2:0] ADDR_A      = 3'b000;
    localparam logic [2:0] ADDR_B      = 3'b001;
    localparam logic [2:0] ADDR_CTRL   = 3'b010;
    localparam logic [2:0] ADDR_STATUS = 3'b011;
    localparam logic [2:0] ADDR_RES_LO = 3'b100;
    localparam logic [2:0] ADDR_RES_HI = 3'b101;

    // CTRL bit positions
    localparam int CTRL_START  = 0;
    localparam int CTRL_OP_LSB = 1;
    localparam int CTRL_OP_MSB = 2;
    localparam int CTRL_IRQ_EN = 3;

    // STATUS bit positions
    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;
    localparam int STATUS_DIV0 = 2;

    // Core sequencing states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } core_state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_core.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_core
//  Description : Iterative WIDTH-cycle shift-add multiplier / restoring
//                divider on magnitudes, with a final sign-fix cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done_pulse,
    output logic             o_div0,
    output logic [WIDTH-1:0] o_res_lo,
    output logic [WIDTH-1:0] o_res_hi
);
    import muldiv_pkg::*;

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam int                 c_w2    = 2 * WIDTH;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    core_state_t        r_state;
    core_state_t        w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_is_div;
    logic               r_sa;
    logic               r_sb;
    logic               r_bzero;
    logic               r_div0;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_mb;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_res_lo;
    logic [WIDTH-1:0]   r_res_hi;

    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_div_diff;
    logic [c_w2-1:0]    w_prod;
    logic [c_w2-1:0]    w_prod_s;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    // Sign stripping happens on the live operands so the snapshot holds magnitudes
    assign w_neg_a = i_op[0] & i_a[WIDTH-1];
    assign w_neg_b = i_op[0] & i_b[WIDTH-1];
    assign w_mag_a = w_neg_a ? (~i_a + WIDTH'(1)) : i_a;
    assign w_mag_b = w_neg_b ? (~i_b + WIDTH'(1)) : i_b;

    // Multiply step: conditionally add multiplicand to the upper half, shift right
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mb} : '0);

    // Divide step: shift next dividend bit into the partial remainder, trial-subtract
    assign w_rem_sh   = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge   = (w_rem_sh >= {1'b0, r_mb});
    assign w_div_diff = w_rem_sh[WIDTH-1:0] - r_mb;

    // Sign fix-up applied in the last cycle
    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = (r_sa ^ r_sb) ? (~w_prod + c_w2'(1)) : w_prod;
    assign w_quo    = (r_sa ^ r_sb) ? (~r_lo + WIDTH'(1)) : r_lo;
    assign w_rem    = r_sa ? (~r_hi + WIDTH'(1)) : r_hi;

    assign o_busy       = (r_state != ST_IDLE);
    assign o_done_pulse = (r_state == ST_FIX);
    assign o_div0       = r_div0;
    assign o_res_lo     = r_res_lo;
    assign o_res_hi     = r_res_hi;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: IDLE -> RUN for WIDTH steps -> FIX -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == c_last) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: snapshot on start, one iteration per RUN cycle, results on FIX
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_bzero  <= 1'b0;
            r_div0   <= 1'b0;
            r_a      <= '0;
            r_mb     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_lo <= '0;
            r_res_hi <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_cnt    <= '0;
                        r_is_div <= i_op[1];
                        r_sa     <= w_neg_a;
                        r_sb     <= w_neg_b;
                        r_bzero  <= (i_b == '0);
                        r_div0   <= 1'b0;
                        r_a      <= i_a;
                        r_mb     <= w_mag_b;
                        r_hi     <= '0;
                        r_lo     <= w_mag_a;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    if (r_is_div) begin
                        r_hi <= w_div_ge ? w_div_diff : w_rem_sh[WIDTH-1:0];
                        r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
                    end else begin
                        r_hi <= w_mul_sum[WIDTH:1];
                        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                    end
                end
                ST_FIX: begin
                    if (r_is_div && r_bzero) begin
                        // Divide by zero: all-ones quotient, dividend as remainder
                        r_res_lo <= '1;
                        r_res_hi <= r_a;
                        r_div0   <= 1'b1;
                    end else if (r_is_div) begin
                        r_res_lo <= w_quo;
                        r_res_hi <= w_rem;
                    end else begin
                        r_res_lo <= w_prod_s[WIDTH-1:0];
                        r_res_hi <= w_prod_s[c_w2-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/peripheral_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : peripheral_muldiv
//  Description : Memory-mapped multiply/divide peripheral: register map,
//                start handshake, sticky done, interrupt, registered read.
//  Revision    : 1.0 - initial release
// ============================================================================
module peripheral_muldiv #(
    parameter int WIDTH    = 32,
    parameter int CLK_FREQ = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [2:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic        irq
);
    import muldiv_pkg::*;

    generate
        if (WIDTH < 4 || WIDTH > 32 || CLK_FREQ <= 0) begin : g_param_check
            $error("peripheral_muldiv: WIDTH must be 4..32 and CLK_FREQ positive");
        end
    endgenerate

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic             r_irq_en;
    logic             r_done;
    logic             r_irq;
    logic [31:0]      r_dout;

    logic             w_rd_stb;
    logic             w_wr_stb;
    logic             w_start;
    logic             w_status_rd;
    logic [31:0]      w_rd_data;
    logic             w_busy;
    logic             w_done_pulse;
    logic             w_div0;
    logic [WIDTH-1:0] w_res_lo;
    logic [WIDTH-1:0] w_res_hi;

    assign w_rd_stb    = cs & rd;
    assign w_wr_stb    = cs & wr;
    assign w_start     = w_wr_stb && (addr == ADDR_CTRL) && d_in[CTRL_START] && !w_busy;
    assign w_status_rd = w_rd_stb && (addr == ADDR_STATUS);

    assign d_out = r_dout;
    assign irq   = r_irq;

    muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_start),
        .i_op         (d_in[CTRL_OP_MSB:CTRL_OP_LSB]),
        .i_a          (r_a),
        .i_b          (r_b),
        .o_busy       (w_busy),
        .o_done_pulse (w_done_pulse),
        .o_div0       (w_div0),
        .o_res_lo     (w_res_lo),
        .o_res_hi     (w_res_hi)
    );

    // Operand and control registers; CTRL is frozen while the core is busy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_MULU;
            r_irq_en <= 1'b0;
        end else if (w_wr_stb) begin
            case (addr)
                ADDR_A: r_a <= d_in[WIDTH-1:0];
                ADDR_B: r_b <= d_in[WIDTH-1:0];
                ADDR_CTRL: begin
                    if (!w_busy) begin
                        r_op     <= d_in[CTRL_OP_MSB:CTRL_OP_LSB];
                        r_irq_en <= d_in[CTRL_IRQ_EN];
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky done: a completing operation outranks a same-cycle STATUS read
    always_ff @(posedge clk) begin
        if (rst)               r_done <= 1'b0;
        else if (w_start)      r_done <= 1'b0;
        else if (w_done_pulse) r_done <= 1'b1;
        else if (w_status_rd)  r_done <= 1'b0;
    end

    // Interrupt follows done one cycle later when enabled
    always_ff @(posedge clk) begin
        if (rst) r_irq <= 1'b0;
        else     r_irq <= r_done & r_irq_en;
    end

    // Read multiplexer; narrow values are zero-extended
    always_comb begin
        w_rd_data = '0;
        case (addr)
            ADDR_A:      w_rd_data = 32'(r_a);
            ADDR_B:      w_rd_data = 32'(r_b);
            ADDR_CTRL: begin
                w_rd_data[CTRL_IRQ_EN]             = r_irq_en;
                w_rd_data[CTRL_OP_MSB:CTRL_OP_LSB] = r_op;
            end
            ADDR_STATUS: begin
                w_rd_data[STATUS_DIV0] = w_div0;
                w_rd_data[STATUS_DONE] = r_done;
                w_rd_data[STATUS_BUSY] = w_busy;
            end
            ADDR_RES_LO: w_rd_data = 32'(w_res_lo);
            ADDR_RES_HI: w_rd_data = 32'(w_res_hi);
            default:     w_rd_data = '0;
        endcase
    end

    // Registered read data, zero whenever no read strobe is present
    always_ff @(posedge clk) begin
        if (rst)           r_dout <= '0;
        else if (w_rd_stb) r_dout <= w_rd_data;
        else               r_dout <= '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_peripheral_muldiv
//  Description : Directed self-checking bench for peripheral_muldiv with a
//                32-bit and an 8-bit instance sharing clock, reset and bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_muldiv;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_in;
    logic [2:0]  addr;
    logic        rd;
    logic        wr;
    logic        cs32;
    logic        cs8;
    logic [31:0] d_out32;
    logic [31:0] d_out8;
    logic        irq32;
    logic        irq8;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    peripheral_muldiv #(.WIDTH(32), .CLK_FREQ(25000000)) u_dut32 (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .cs    (cs32),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out32),
        .irq   (irq32)
    );

    peripheral_muldiv #(.WIDTH(8), .CLK_FREQ(25000000)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .cs    (cs8),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out8),
        .irq   (irq8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input int sel, input logic [2:0] a, input logic [31:0] d);
        cs32 = (sel == 0);
        cs8  = (sel == 1);
        wr   = 1'b1;
        addr = a;
        d_in = d;
        tick();
        cs32 = 1'b0;
        cs8  = 1'b0;
        wr   = 1'b0;
        d_in = '0;
    endtask

    // Expected value is queued as the read is issued and retired when d_out appears
    task automatic bus_read(input int sel, input logic [2:0] a, input logic [31:0] exp,
                            input string tag);
        logic [31:0] obs;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        cs32 = (sel == 0);
        cs8  = (sel == 1);
        rd   = 1'b1;
        addr = a;
        tick();
        cs32 = 1'b0;
        cs8  = 1'b0;
        rd   = 1'b0;
        obs  = (sel == 1) ? d_out8 : d_out32;
        check(tag_q.pop_front(), obs, exp_q.pop_front());
    endtask

    // Start an op, poll STATUS through the whole busy window, then check final STATUS
    task automatic run_op(input int sel, input logic [1:0] op, input logic irq_en,
                          input logic [31:0] final_status, input string tag);
        int w;
        w = (sel == 1) ? 8 : 32;
        bus_write(sel, ADDR_CTRL, {28'd0, irq_en, op, 1'b1});
        for (int k = 0; k < w + 1; k++)
            bus_read(sel, ADDR_STATUS, 32'h1, $sformatf("%s_busy%0d", tag, k));
        bus_read(sel, ADDR_STATUS, final_status, {tag, "_status"});
    endtask

    initial begin
        rst  = 1'b1;
        d_in = '0;
        addr = '0;
        rd   = 1'b0;
        wr   = 1'b0;
        cs32 = 1'b0;
        cs8  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_dout", d_out32, 32'h0);
        check("rst_irq32", {31'd0, irq32}, 32'h0);
        check("rst_irq8", {31'd0, irq8}, 32'h0);
        bus_read(0, ADDR_A, 32'h0, "rst_a");
        bus_read(0, ADDR_B, 32'h0, "rst_b");
        bus_read(0, ADDR_CTRL, 32'h0, "rst_ctrl");
        bus_read(0, ADDR_STATUS, 32'h0, "rst_status");
        bus_read(0, ADDR_RES_LO, 32'h0, "rst_res_lo");
        bus_read(0, ADDR_RES_HI, 32'h0, "rst_res_hi");

        // MULU full-width
        bus_write(0, ADDR_A, 32'hFFFF_FFFF);
        bus_write(0, ADDR_B, 32'h0000_0002);
        run_op(0, OP_MULU, 1'b0, 32'h2, "mulu");
        bus_read(0, ADDR_STATUS, 32'h0, "mulu_status_clr");
        bus_read(0, ADDR_RES_HI, 32'h0000_0001, "mulu_hi");
        bus_read(0, ADDR_RES_LO, 32'hFFFF_FFFE, "mulu_lo");
        tick();
        check("idle_dout", d_out32, 32'h0);
        bus_write(0, 3'b110, 32'hDEAD_BEEF);
        bus_read(0, 3'b110, 32'h0, "reserved6");
        bus_read(0, 3'b111, 32'h0, "reserved7");

        // MULS
        bus_write(0, ADDR_A, 32'hFFFF_FFFD);
        bus_write(0, ADDR_B, 32'h0000_0007);
        run_op(0, OP_MULS, 1'b0, 32'h2, "muls");
        bus_read(0, ADDR_RES_HI, 32'hFFFF_FFFF, "muls_hi");
        bus_read(0, ADDR_RES_LO, 32'hFFFF_FFEB, "muls_lo");
        bus_read(0, ADDR_CTRL, 32'h2, "muls_ctrl");

        // DIVS -7 / 2
        bus_write(0, ADDR_A, 32'hFFFF_FFF9);
        bus_write(0, ADDR_B, 32'h0000_0002);
        run_op(0, OP_DIVS, 1'b0, 32'h2, "divs");
        bus_read(0, ADDR_RES_LO, 32'hFFFF_FFFD, "divs_quo");
        bus_read(0, ADDR_RES_HI, 32'hFFFF_FFFF, "divs_rem");

        // DIVU by zero
        bus_write(0, ADDR_A, 32'd100);
        bus_write(0, ADDR_B, 32'd0);
        run_op(0, OP_DIVU, 1'b0, 32'h6, "div0");
        bus_read(0, ADDR_RES_LO, 32'hFFFF_FFFF, "div0_quo");
        bus_read(0, ADDR_RES_HI, 32'd100, "div0_rem");

        // DIVS overflow; div0 must clear on the new start
        bus_write(0, ADDR_A, 32'h8000_0000);
        bus_write(0, ADDR_B, 32'hFFFF_FFFF);
        run_op(0, OP_DIVS, 1'b0, 32'h2, "divs_ovf");
        bus_read(0, ADDR_RES_LO, 32'h8000_0000, "divs_ovf_quo");
        bus_read(0, ADDR_RES_HI, 32'h0, "divs_ovf_rem");

        // 8-bit MULU with irq, ignored start while busy, A rewritten mid-run
        bus_write(1, ADDR_A, 32'hFF);
        bus_write(1, ADDR_B, 32'hFF);
        bus_write(1, ADDR_CTRL, 32'h9);
        bus_write(1, ADDR_A, 32'h5);
        bus_write(1, ADDR_CTRL, 32'h7);
        repeat (7) tick();
        check("w8_irq_early", {31'd0, irq8}, 32'h0);
        tick();
        check("w8_irq_set", {31'd0, irq8}, 32'h1);
        bus_read(1, ADDR_STATUS, 32'h2, "w8_status");
        check("w8_irq_hold", {31'd0, irq8}, 32'h1);
        tick();
        check("w8_irq_clr", {31'd0, irq8}, 32'h0);
        bus_read(1, ADDR_RES_LO, 32'h01, "w8_lo");
        bus_read(1, ADDR_RES_HI, 32'hFE, "w8_hi");
        bus_read(1, ADDR_A, 32'h05, "w8_a");
        bus_read(1, ADDR_CTRL, 32'h8, "w8_ctrl");
        check("w8_irq32_quiet", {31'd0, irq32}, 32'h0);

        // 8-bit MULS, results zero-extended
        bus_write(1, ADDR_A, 32'h80);
        bus_write(1, ADDR_B, 32'h80);
        run_op(1, OP_MULS, 1'b0, 32'h2, "w8_muls");
        bus_read(1, ADDR_RES_LO, 32'h00, "w8_muls_lo");
        bus_read(1, ADDR_RES_HI, 32'h40, "w8_muls_hi");

        // Reset in the middle of a DIVU
        bus_write(0, ADDR_A, 32'd100);
        bus_write(0, ADDR_B, 32'd7);
        bus_write(0, ADDR_CTRL, {28'd0, 1'b0, OP_DIVU, 1'b1});
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_read(0, ADDR_STATUS, 32'h0, "rst_mid_status");
        bus_read(0, ADDR_RES_LO, 32'h0, "rst_mid_lo");
        bus_read(0, ADDR_RES_HI, 32'h0, "rst_mid_hi");
        bus_read(0, ADDR_A, 32'h0, "rst_mid_a");
        bus_write(0, ADDR_A, 32'd100);
        bus_write(0, ADDR_B, 32'd7);
        run_op(0, OP_DIVU, 1'b0, 32'h2, "divu_after_rst");
        bus_read(0, ADDR_RES_LO, 32'd14, "divu_quo");
        bus_read(0, ADDR_RES_HI, 32'd2, "divu_rem");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
